// File: rtl/xgmii_rx_link_monitor.sv
// xgmii_rx_link_monitor
//
// Link-fault monitor between the 10GBASE-R PHY receive XGMII and the MAC.
// It detects local/remote fault sequences (IEEE 802.3 clause 46) on the 72-bit
// two-column data/control bus and drives the resulting fault status. Received
// words are passed to the MAC one cycle later, with idles substituted while a
// fault is active. A saturating counter records columns containing /E/.
//
// Ports
//   clk            156.25 MHz XGMII receive clock
//   rst_n          asynchronous active-low reset
//   phy_rx_ready   PHY receive-ready; low forces local fault
//   rx_dc_in       PHY word, lane i = [9i+8:9i] (bit 9i+8 = control)
//                  lanes 0-3 = column A (earlier), lanes 4-7 = column B
//   rx_dc_out      registered word to the MAC, same format
//   link_fault     00 ok, 01 local fault, 10 remote fault
//   link_ok        high when link_fault == 00
//   err_count      saturating count of columns holding an /E/ character
//   err_count_clr  synchronous clear of err_count
//
// Fault state
//   state        | meaning
//   FAULT_OK     | link up, data passed through
//   FAULT_LOCAL  | local fault (received LF run or PHY not ready), idles sent
//   FAULT_REMOTE | remote fault (received RF run), idles sent

module xgmii_rx_link_monitor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phy_rx_ready,
  input  logic [71:0] rx_dc_in,
  output logic [71:0] rx_dc_out,
  output logic [1:0]  link_fault,
  output logic        link_ok,
  output logic [15:0] err_count,
  input  logic        err_count_clr
);

  localparam logic [71:0] IDLE72 = {8{9'h107}};

  typedef enum logic [1:0] {
    FAULT_OK     = 2'b00,
    FAULT_LOCAL  = 2'b01,
    FAULT_REMOTE = 2'b10
  } fault_e;

  typedef struct packed {
    fault_e     fault;
    logic [1:0] last_type;
    logic [2:0] seq_cnt;
    logic [6:0] col_cnt;
  } mon_t;

  localparam mon_t RESET_STATE = '{fault: FAULT_LOCAL, last_type: 2'b00,
                                   seq_cnt: 3'd0, col_cnt: 7'd0};

  // One column's effect on the sequence/fault tracker.
  function automatic mon_t col_step(input mon_t s, input logic [35:0] col);
    mon_t       n;
    logic       is_seq;
    logic [1:0] seq_type;
    n        = s;
    // Lane3 is 9'h001 (LF) or 9'h002 (RF); its low two bits give the type
    // directly in link_fault encoding.
    seq_type = col[28:27];
    is_seq   = (col[8:0] == 9'h19C) && (col[17:9] == 9'h000) &&
               (col[26:18] == 9'h000) &&
               ((col[35:27] == 9'h001) || (col[35:27] == 9'h002));
    if (is_seq) begin
      n.col_cnt = 7'd0;
      if (seq_type == s.last_type) begin
        if (s.seq_cnt != 3'd4) n.seq_cnt = s.seq_cnt + 3'd1;
      end else begin
        n.last_type = seq_type;
        n.seq_cnt   = 3'd1;
      end
      if (n.seq_cnt == 3'd4) n.fault = fault_e'(seq_type);
    end else if (s.col_cnt == 7'd127) begin
      // 128 consecutive non-sequence columns: fault clears and the run resets.
      n = '{fault: FAULT_OK, last_type: 2'b00, seq_cnt: 3'd0, col_cnt: 7'd0};
    end else begin
      n.col_cnt = s.col_cnt + 7'd1;
    end
    return n;
  endfunction

  function automatic logic col_has_err(input logic [35:0] col);
    return (col[8:0] == 9'h1FE) || (col[17:9] == 9'h1FE) ||
           (col[26:18] == 9'h1FE) || (col[35:27] == 9'h1FE);
  endfunction

  mon_t        state_q;
  mon_t        state_mid;
  mon_t        state_d;
  logic [71:0] data_d;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      rx_dc_out <= IDLE72;
      err_count <= 16'd0;
    end else begin
      state_q   <= state_d;
      rx_dc_out <= data_d;
      err_count <= err_d;
    end
  end

  always_comb begin
    state_mid = state_q;
    state_d   = state_q;
    data_d    = IDLE72;
    err_inc   = 2'd0;
    err_sum   = 17'd0;
    err_d     = err_count;

    // Column B sees the tracker as left by column A.
    state_mid = col_step(state_q, rx_dc_in[35:0]);
    if (phy_rx_ready) begin
      state_d = col_step(state_mid, rx_dc_in[71:36]);
    end else begin
      state_d = RESET_STATE;
    end

    if (state_d.fault == FAULT_OK) data_d = rx_dc_in;

    err_inc = {1'b0, col_has_err(rx_dc_in[35:0])} +
              {1'b0, col_has_err(rx_dc_in[71:36])};
    err_sum = {1'b0, err_count} + {15'd0, err_inc};
    if (err_count_clr) begin
      err_d = 16'd0;
    end else if (phy_rx_ready) begin
      err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign link_fault = state_q.fault;
  assign link_ok    = (state_q.fault == FAULT_OK);

endmodule

// File: tb/tb_xgmii_rx_link_monitor.sv
// Testbench for xgmii_rx_link_monitor: directed vector table, hand-written
// multi-cycle sequences and randomized traffic checked against a column-level
// reference model.

module tb_xgmii_rx_link_monitor;

  logic        clk;
  logic        rst_n;
  logic        phy_rx_ready;
  logic [71:0] rx_dc_in;
  logic [71:0] rx_dc_out;
  logic [1:0]  link_fault;
  logic        link_ok;
  logic [15:0] err_count;
  logic        err_count_clr;

  xgmii_rx_link_monitor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .phy_rx_ready  (phy_rx_ready),
    .rx_dc_in      (rx_dc_in),
    .rx_dc_out     (rx_dc_out),
    .link_fault    (link_fault),
    .link_ok       (link_ok),
    .err_count     (err_count),
    .err_count_clr (err_count_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [71:0] idle72;
  logic [35:0] idle_col, lf_col, rf_col, bad_col;
  logic [71:0] w_lf, w_rf, w_lfa_rfb, w_bad, w_err;

  // Reference model state (integers, column-at-a-time).
  int          m_fault, m_last, m_seq, m_col, m_err;
  logic [71:0] m_out;

  typedef struct {
    logic        rdy;
    logic        clr;
    logic [71:0] word;
    logic [1:0]  exp_fault;
    logic        exp_pass;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fault = 1; m_last = 0; m_seq = 0; m_col = 0; m_err = 0;
    m_out = idle72;
  endtask

  function automatic int seq_type_of(input logic [35:0] c);
    if (c[8:0] == 9'h19C && c[17:9] == 9'h000 && c[26:18] == 9'h000) begin
      if (c[35:27] == 9'h001) return 1;
      if (c[35:27] == 9'h002) return 2;
    end
    return 0;
  endfunction

  function automatic int is_err_col(input logic [35:0] c);
    for (int i = 0; i < 4; i++)
      if (c[9*i +: 9] == 9'h1FE) return 1;
    return 0;
  endfunction

  task automatic model_col(input logic [35:0] c);
    int t;
    t = seq_type_of(c);
    if (t != 0) begin
      m_col = 0;
      if (t == m_last) m_seq = (m_seq + 1 > 4) ? 4 : m_seq + 1;
      else begin
        m_last = t;
        m_seq  = 1;
      end
      if (m_seq == 4) m_fault = t;
    end else if (m_col == 127) begin
      m_col = 0; m_seq = 0; m_last = 0; m_fault = 0;
    end else begin
      m_col++;
    end
  endtask

  task automatic model_step(input logic rdy, input logic [71:0] w, input logic clr);
    int n;
    if (!rdy) begin
      m_fault = 1; m_seq = 0; m_col = 0; m_last = 0;
    end else begin
      model_col(w[35:0]);
      model_col(w[71:36]);
    end
    n = is_err_col(w[35:0]) + is_err_col(w[71:36]);
    if (clr) m_err = 0;
    else if (rdy) m_err = (m_err + n > 65535) ? 65535 : m_err + n;
    m_out = (m_fault == 0) ? w : idle72;
  endtask

  task automatic check_model();
    chk("link_fault", {70'd0, link_fault}, 72'(m_fault));
    chk("link_ok", {71'd0, link_ok}, {71'd0, (m_fault == 0)});
    chk("err_count", {56'd0, err_count}, 72'(m_err));
    chk("rx_dc_out", rx_dc_out, m_out);
  endtask

  task automatic cycle(input logic rdy, input logic [71:0] w, input logic clr);
    phy_rx_ready  = rdy;
    rx_dc_in      = w;
    err_count_clr = clr;
    model_step(rdy, w, clr);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic go_ok();
    repeat (64) cycle(1'b1, idle72, 1'b0);
  endtask

  function automatic logic [35:0] make_col(input int kind);
    logic [35:0] c;
    case (kind)
      1: c = lf_col;
      2: c = rf_col;
      3: c = bad_col;
      4: begin c = idle_col; c[17:9] = 9'h1FE; end
      5: c = {4'($urandom_range(0, 15)), 32'($urandom)};
      default: c = idle_col;
    endcase
    return c;
  endfunction

  function automatic int pick_kind(input int mode);
    int r;
    r = $urandom_range(0, 99);
    case (mode)
      0: return (r < 90) ? 0 : (r < 95) ? 4 : 5;
      1: return (r < 70) ? 1 : 0;
      2: return (r < 70) ? 2 : (r < 85) ? 0 : 4;
      default: return $urandom_range(0, 5);
    endcase
  endfunction

  initial begin
    logic [71:0] w;
    int mode;

    idle_col  = {4{9'h107}};
    idle72    = {idle_col, idle_col};
    lf_col    = {9'h001, 9'h000, 9'h000, 9'h19C};
    rf_col    = {9'h002, 9'h000, 9'h000, 9'h19C};
    bad_col   = {9'h003, 9'h000, 9'h000, 9'h19C};
    w_lf      = {lf_col, lf_col};
    w_rf      = {rf_col, rf_col};
    w_lfa_rfb = {rf_col, lf_col};
    w_bad     = {bad_col, bad_col};
    w_err     = idle72;
    w_err[26:18] = 9'h1FE;
    w_err[62:54] = 9'h1FE;

    // Table, starting from a freshly cleared link.
    tbl[0] = '{1'b1, 1'b0, w_lf,      2'b00, 1'b1};
    tbl[1] = '{1'b1, 1'b0, w_bad,     2'b00, 1'b1};
    tbl[2] = '{1'b1, 1'b0, w_lf,      2'b01, 1'b0};
    tbl[3] = '{1'b1, 1'b0, w_rf,      2'b01, 1'b0};
    tbl[4] = '{1'b1, 1'b0, w_lfa_rfb, 2'b01, 1'b0};
    tbl[5] = '{1'b1, 1'b0, w_rf,      2'b01, 1'b0};
    tbl[6] = '{1'b1, 1'b0, w_rf,      2'b10, 1'b0};
    tbl[7] = '{1'b0, 1'b0, idle72,    2'b01, 1'b0};
    tbl[8] = '{1'b1, 1'b0, w_rf,      2'b01, 1'b0};
    tbl[9] = '{1'b1, 1'b0, w_rf,      2'b10, 1'b0};

    rst_n = 1'b0;
    phy_rx_ready = 1'b1;
    rx_dc_in = idle72;
    err_count_clr = 1'b0;
    model_reset();
    #12;
    chk("reset link_fault", {70'd0, link_fault}, 72'd1);
    chk("reset link_ok", {71'd0, link_ok}, 72'd0);
    chk("reset err_count", {56'd0, err_count}, 72'd0);
    chk("reset rx_dc_out", rx_dc_out, idle72);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Clear from reset: 128 clean columns.
    for (int k = 1; k <= 64; k++) begin
      w = {make_col(5), make_col(5)};
      cycle(1'b1, w, 1'b0);
      chk("clear link_fault", {70'd0, link_fault}, (k < 64) ? 72'd1 : 72'd0);
      chk("clear rx_dc_out", rx_dc_out, (k < 64) ? idle72 : w);
    end

    // Two LF words set local fault.
    cycle(1'b1, w_lf, 1'b0);
    chk("lf1 link_fault", {70'd0, link_fault}, 72'd0);
    chk("lf1 rx_dc_out", rx_dc_out, w_lf);
    cycle(1'b1, w_lf, 1'b0);
    chk("lf2 link_fault", {70'd0, link_fault}, 72'd1);
    chk("lf2 rx_dc_out", rx_dc_out, idle72);

    // Alternating LF/RF columns never build a run.
    go_ok();
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, w_lfa_rfb, 1'b0);
      chk("alt rx_dc_out", rx_dc_out, w_lfa_rfb);
      chk("alt link_fault", {70'd0, link_fault}, 72'd0);
    end

    // RF run survives a 126-column gap.
    go_ok();
    cycle(1'b1, w_rf, 1'b0);
    repeat (63) cycle(1'b1, idle72, 1'b0);
    cycle(1'b1, w_rf, 1'b0);
    chk("gap63 link_fault", {70'd0, link_fault}, 72'd2);

    // A 128-column gap resets the run.
    go_ok();
    cycle(1'b1, w_rf, 1'b0);
    repeat (64) cycle(1'b1, idle72, 1'b0);
    cycle(1'b1, w_rf, 1'b0);
    chk("gap64 link_fault", {70'd0, link_fault}, 72'd0);

    // Vector table.
    go_ok();
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rdy, tbl[i].word, tbl[i].clr);
      chk($sformatf("tbl%0d link_fault", i), {70'd0, link_fault}, {70'd0, tbl[i].exp_fault});
      chk($sformatf("tbl%0d rx_dc_out", i), rx_dc_out, tbl[i].exp_pass ? tbl[i].word : idle72);
    end

    // PHY not ready for one cycle.
    go_ok();
    cycle(1'b0, idle72, 1'b0);
    chk("nrdy link_fault", {70'd0, link_fault}, 72'd1);
    repeat (63) cycle(1'b1, idle72, 1'b0);
    chk("nrdy63 link_fault", {70'd0, link_fault}, 72'd1);
    cycle(1'b1, idle72, 1'b0);
    chk("nrdy64 link_fault", {70'd0, link_fault}, 72'd0);

    // Asynchronous reset mid-stream.
    cycle(1'b1, w_err, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst link_fault", {70'd0, link_fault}, 72'd1);
    chk("arst link_ok", {71'd0, link_ok}, 72'd0);
    chk("arst err_count", {56'd0, err_count}, 72'd0);
    chk("arst rx_dc_out", rx_dc_out, idle72);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic.
    mode = 0;
    for (int k = 0; k < 3000; k++) begin
      logic rdy, clr;
      if (k % 40 == 0) mode = $urandom_range(0, 3);
      rdy = ($urandom_range(0, 63) != 0);
      clr = rdy && ($urandom_range(0, 99) == 0);
      w = {make_col(pick_kind(mode)), make_col(pick_kind(mode))};
      cycle(rdy, w, clr);
    end

    // Error counter saturation and clear.
    cycle(1'b1, w_err, 1'b1);
    chk("sat clr0", {56'd0, err_count}, 72'd0);
    for (int i = 1; i <= 36000; i++) begin
      cycle(1'b1, w_err, 1'b0);
      if (i == 32767) chk("sat fffe", {56'd0, err_count}, 72'hFFFE);
      if (i == 32768) chk("sat ffff", {56'd0, err_count}, 72'hFFFF);
    end
    chk("sat hold", {56'd0, err_count}, 72'hFFFF);
    cycle(1'b1, w_err, 1'b1);
    chk("sat clr", {56'd0, err_count}, 72'd0);
    cycle(1'b1, w_err, 1'b0);
    chk("sat resume2", {56'd0, err_count}, 72'd2);
    cycle(1'b1, w_err, 1'b0);
    chk("sat resume4", {56'd0, err_count}, 72'd4);
    repeat (3997) cycle(1'b1, w_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xgmii_rx_link_monitor.md
# xgmii_rx_link_monitor

Sits between the 10GBASE-R PHY receive XGMII output and the MAC receive XGMII input, in the 156.25 MHz domain. Implements IEEE 802.3 clause 46 link-fault detection on the 72-bit PHY data/control bus and drives fault and link status. Passes received data to the MAC with one register stage, substituting idles while a fault is active. Keeps a saturating error-character counter for diagnostics.

## Interface
- No parameters.
- clk  in  1  156.25 MHz XGMII receive clock, shared with the PHY receive side
- rst_n  in  1  asynchronous, active-low reset
- phy_rx_ready  in  1  PHY receive-ready; low forces local fault
- rx_dc_in  in  72  PHY XGMII word; lane i = bits [9i+8:9i], bit 9i+8 = control flag, bits [9i+7:9i] = byte; lanes 0-3 = column A (earlier), lanes 4-7 = column B
- rx_dc_out  out  72  registered word to the MAC, same format
- link_fault  out  2  00 OK, 01 local fault, 10 remote fault
- link_ok  out  1  high when link_fault == 00
- err_count  out  16  saturating count of columns containing an /E/ character
- err_count_clr  in  1  synchronous clear of err_count

## Operation
- Idle word IDLE72: every lane = 9'h107.
- A column is a fault sequence when lane0 = 9'h19C, lanes 1 and 2 = 9'h000, and lane3 = 9'h001 (local, LF) or 9'h002 (remote, RF). Any other lane3 value is not a fault sequence.
- An error column has any lane = 9'h1FE.
- State registers: fault[1:0], last_type[1:0], seq_cnt[2:0] (range 0-4), col_cnt[6:0] (range 0-127).
- Column A is evaluated, then column B, using A's result, in one cycle's combinational logic. All registers update once per cycle.
- Per-column update:
  - Fault sequence of type T:
    - col_cnt := 0.
    - If T == last_type, seq_cnt := min(seq_cnt+1, 4). Otherwise last_type := T and seq_cnt := 1.
    - If the new seq_cnt == 4, fault := T.
  - Any other column:
    - If col_cnt == 127: col_cnt := 0, seq_cnt := 0, last_type := 00, fault := 00.
    - Otherwise col_cnt := col_cnt+1.
- When phy_rx_ready is low during a cycle, column evaluation is skipped. At the next edge: fault := 01, seq_cnt := 0, col_cnt := 0, last_type := 00. err_count is held.
- err_count increments by the number of error columns in the word (0, 1 or 2), saturating at 16'hFFFF. err_count_clr takes priority: the register loads 0 and that cycle's errors are discarded.
- rx_dc_out := rx_dc_in when the post-update fault == 00; otherwise IDLE72.

## Timing
- Reset values: rx_dc_out = IDLE72, link_fault = 01, link_ok = 0, err_count = 0, seq_cnt = 0, col_cnt = 0, last_type = 00.
- Fault set and clear take effect at the edge after the deciding word. Status and substituted data change on the same edge.
- rx_dc_out latency is 1 cycle.
- Clearing from reset takes 128 non-fault columns, i.e. 64 cycles. link_ok rises at the edge ending the 64th clean cycle.
- Setting a fault needs 4 consecutive same-type sequences with no 128-column gap. Two fault-sequence words (A and B both sequences) set the fault in 2 cycles.
- A type change resets the sequence run to 1 of the new type. The current fault value is held until a new run reaches 4 or a clear occurs.
- Asserting rst_n low mid-stream returns all outputs to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then 64 cycles of IDLE72 -> link_fault stays 01 through cycle 63, becomes 00 after cycle 64; rx_dc_out stays IDLE72 until the cycle after clear.
- From OK, drive 2 words with both columns = LF sequence (lane3 = 9'h001) -> link_fault = 01 after the 2nd word; rx_dc_out = IDLE72 from the 2nd output onward.
- From OK, alternate LF/RF columns for 20 cycles -> seq_cnt never reaches 4; link_fault stays 00 and data passes through unchanged with 1-cycle latency.
- From OK, 1 RF word, then 63 idle cycles, then 1 RF word -> the run continues (seq_cnt 2→3... no 128-column gap); a 64-cycle idle gap instead resets seq_cnt, and the following RF pair does not set the fault.
- Drive 9'h1FE in lanes 2 and 6 for 40000 cycles, pulse err_count_clr once mid-run -> err_count saturates at 16'hFFFF, is 0 the cycle after the clear, then resumes counting by 2 per cycle.
- Deassert phy_rx_ready for 1 cycle while OK -> link_fault = 01 next edge; a further 64 clean cycles return it to 00.
